// File: rtl/pipe_pkg.sv
// Shared helpers for the elastic pipeline chain: width derivation and
// occupancy popcount.
package pipe_pkg;

  localparam int POP_MAX = 64;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] popcount(input logic [POP_MAX-1:0] v);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < POP_MAX; i++) begin
      c = c + {7'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One elastic slot: a main register plus a skid register so the upstream
// ready can come straight from a flop.
module pipe_skid_slot #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             up_ready,
  output logic             down_valid,
  output logic [WIDTH-1:0] down_data,
  input  logic             down_ready,
  output logic [1:0]       occ
);

  logic             main_valid;
  logic             skid_valid;
  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] skid_data;
  logic             pop;
  logic             push;

  assign up_ready   = !skid_valid;
  assign down_valid = main_valid;
  assign down_data  = main_data;
  assign occ        = {skid_valid, main_valid};

  assign pop  = main_valid & down_ready;
  assign push = up_valid & !skid_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      // flush kills words but leaves the data flops alone
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || pop) begin
      if (skid_valid) begin
        main_data  <= skid_data;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (push) begin
        main_data  <= up_data;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (push) begin
      skid_data  <= up_data;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_chain.sv
// Stallable, flushable register boundary built from STAGES chained skid
// slots with a valid/ready handshake on both ends.
module pipe_chain
  import pipe_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2,
  parameter int CW     = clog2(2*STAGES+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CW-1:0]    count
);

  logic [STAGES:0]     valid_link;
  logic [STAGES:0]     ready_link;
  logic [WIDTH-1:0]    data_link [STAGES+1];
  logic [2*STAGES-1:0] flags;
  logic [POP_MAX-1:0]  flags_ext;

  assign valid_link[0]      = in_valid;
  assign data_link[0]       = in_data;
  assign in_ready           = ready_link[0];
  assign ready_link[STAGES] = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_slot
    pipe_skid_slot #(.WIDTH(WIDTH)) u_slot (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .up_valid   (valid_link[k]),
      .up_data    (data_link[k]),
      .up_ready   (ready_link[k]),
      .down_valid (valid_link[k+1]),
      .down_data  (data_link[k+1]),
      .down_ready (ready_link[k+1]),
      .occ        (flags[2*k +: 2])
    );
  end

  assign out_valid = valid_link[STAGES];
  assign out_data  = valid_link[STAGES] ? data_link[STAGES] : '0;

  assign flags_ext = POP_MAX'(flags);
  assign count     = CW'(popcount(flags_ext));

endmodule

// File: tb/tb_pipe_chain.sv
// Directed bench for pipe_chain: a 3-stage and a 1-stage instance driven
// through reset, streaming, back-pressure, flush and a random queue model.
module tb_pipe_chain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  logic        a_rst, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [15:0] a_in_data, a_out_data;
  logic [2:0]  a_count;

  logic        b_rst, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [15:0] b_in_data, b_out_data;
  logic [1:0]  b_count;

  pipe_chain #(.WIDTH(16), .STAGES(3)) u_a (
    .clk(clk), .rst(a_rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
    .count(a_count)
  );

  pipe_chain #(.WIDTH(16), .STAGES(1)) u_b (
    .clk(clk), .rst(b_rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
    .count(b_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int          na, nt, exp_cnt;
  logic        acc, take;
  logic [15:0] q[$];
  int          nb_in, nb_out;

  initial begin
    // 1: reset with a word parked on the input
    a_rst = 1; a_flush = 0; a_in_valid = 1; a_in_data = 16'hBEEF; a_out_ready = 1;
    b_rst = 1; b_flush = 0; b_in_valid = 0; b_in_data = 16'h0; b_out_ready = 0;
    tick(); tick();
    check("t1_out_valid", a_out_valid, 0);
    check("t1_out_data", a_out_data, 16'h0000);
    check("t1_count", a_count, 0);
    check("t1_in_ready", a_in_ready, 1);
    check("t1_b_count", b_count, 0);
    a_rst = 0; b_rst = 0; a_in_valid = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t1_no_beef", a_out_valid, 0);
    end

    // 2: streaming 1..16 with out_ready high
    a_out_ready = 1;
    for (int cyc = 0; cyc < 22; cyc++) begin
      a_in_valid = (cyc < 16);
      a_in_data  = 16'(cyc + 1);
      exp_cnt = ((cyc < 16) ? cyc : 16) - ((cyc < 3) ? 0 : ((cyc - 3 > 16) ? 16 : cyc - 3));
      check("t2_in_ready", a_in_ready, 1);
      check("t2_out_valid", a_out_valid, (cyc >= 3 && cyc < 19));
      check("t2_out_data", a_out_data, (cyc >= 3 && cyc < 19) ? cyc - 2 : 0);
      check("t2_count", a_count, exp_cnt);
      tick();
    end

    // 3: back-pressure fills exactly six words, then drain
    a_out_ready = 0; a_in_valid = 1; na = 0; nt = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      a_in_data = 16'h0100 + 16'(na);
      check("t3_in_ready", a_in_ready, (cyc < 6));
      check("t3_count", a_count, (cyc < 6) ? cyc : 6);
      check("t3_out_valid", a_out_valid, (cyc >= 3));
      if (cyc >= 3) check("t3_head", a_out_data, 16'h0100);
      acc = a_in_ready;
      tick();
      if (acc) na++;
    end
    check("t3_accepted", na, 6);
    a_out_ready = 1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      a_in_valid = (na < 16);
      a_in_data  = 16'h0100 + 16'(na);
      if (cyc <= 3) check("t3_resume_ready", a_in_ready, (cyc == 3));
      take = a_out_valid;
      if (take) check("t3_order", a_out_data, 16'h0100 + 16'(nt));
      acc = a_in_valid & a_in_ready;
      tick();
      if (take) nt++;
      if (acc) na++;
    end
    check("t3_out_total", nt, 16);
    check("t3_in_total", na, 16);
    check("t3_empty", a_count, 0);

    // 4: flush at count 4 with a word on the input
    a_out_ready = 0; a_in_valid = 1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      a_in_data = 16'h0201 + 16'(cyc);
      check("t4_fill_ready", a_in_ready, 1);
      tick();
    end
    check("t4_count_pre", a_count, 4);
    a_flush = 1; a_in_data = 16'h5A5A;
    tick();
    a_flush = 0;
    check("t4_count", a_count, 0);
    check("t4_out_valid", a_out_valid, 0);
    check("t4_out_data", a_out_data, 0);
    check("t4_in_ready", a_in_ready, 1);
    a_in_data = 16'h00C1; a_out_ready = 1;
    tick();
    a_in_valid = 0;
    for (int k = 1; k <= 8; k++) begin
      check("t4_post_valid", a_out_valid, (k == 3));
      check("t4_post_data", a_out_data, (k == 3) ? 16'h00C1 : 16'h0000);
      tick();
    end

    // 5: single stage with out_ready toggling every cycle
    b_in_valid = 1; nb_in = 0; nb_out = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      b_out_ready = cyc[0];
      b_in_data   = 16'h0300 + 16'(nb_in);
      check("t5_count_le2", (b_count <= 2), 1);
      if (!b_in_ready) check("t5_ready_skid", b_count, 2);
      take = b_out_valid & b_out_ready;
      if (take) check("t5_order", b_out_data, 16'h0300 + 16'(nb_out));
      acc = b_in_ready;
      tick();
      if (take) nb_out++;
      if (acc) nb_in++;
    end
    b_in_valid = 0; b_out_ready = 1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (b_out_valid) begin
        check("t5_drain", b_out_data, 16'h0300 + 16'(nb_out));
        nb_out++;
      end
      tick();
    end
    check("t5_balance", nb_out, nb_in);
    check("t5_empty", b_count, 0);

    // 6: random traffic with flush/rst pulses against a queue model
    q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      a_rst       = ($urandom_range(0, 63) == 0);
      a_flush     = ($urandom_range(0, 31) == 0);
      a_in_valid  = ($urandom_range(0, 3) != 0);
      a_out_ready = ($urandom_range(0, 4) < 3);
      a_in_data   = 16'($urandom);
      check("t6_count", a_count, q.size());
      if (a_out_valid) begin
        if (q.size() == 0) check("t6_spurious", a_out_valid, 0);
        else check("t6_head", a_out_data, q[0]);
      end else begin
        check("t6_idle_data", a_out_data, 0);
      end
      if (a_rst) q.delete();
      else begin
        if (a_out_valid && a_out_ready && q.size() > 0) void'(q.pop_front());
        if (a_flush) q.delete();
        else if (a_in_valid && a_in_ready) q.push_back(a_in_data);
      end
      tick();
    end
    a_rst = 0; a_flush = 0; a_in_valid = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
